// File: rtl/stream_expander.sv
// stream_expander
//   Buffers incoming elements (compacted by in_keep) and scatters them onto
//   output lanes selected by a mask stream. Each mask beat consumes
//   popcount(mask_data) buffered elements in arrival order. Unselected lanes
//   carry zero.
//
//   Parameters: NUM_ELEMENTS lanes per beat (>=2), DATA_WIDTH bits per lane.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     in_data/in_keep/in_last       input beat, valid/ready handshake
//     mask_data/mask_last           target lane pattern, valid/ready handshake
//     out_data/out_keep/out_last    expanded beat, valid/ready handshake
//     err                           sticky packet-boundary protocol error

// One output lane: pick buffer entry `sel` when the lane is enabled, else 0.
module stream_expander_lane #(
    parameter int DEPTH = 16,
    parameter int W     = 32,
    parameter int CW    = 5
) (
    input  logic [DEPTH-1:0][W-1:0] fifo,
    input  logic [CW-1:0]           sel,
    input  logic                    en,
    output logic [W-1:0]            elem
);
    always_comb begin
        elem = '0;
        for (int j = 0; j < DEPTH; j++)
            if (en && sel == CW'(j)) elem = fifo[j];
    end
endmodule

module stream_expander #(
    parameter int NUM_ELEMENTS = 8,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_ELEMENTS*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_ELEMENTS-1:0]              in_keep,
    input  logic                                 in_last,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_ELEMENTS-1:0]              mask_data,
    input  logic                                 mask_last,
    input  logic                                 mask_valid,
    output logic                                 mask_ready,
    output logic [NUM_ELEMENTS*DATA_WIDTH-1:0]   out_data,
    output logic [NUM_ELEMENTS-1:0]              out_keep,
    output logic                                 out_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 err
);
    localparam int N     = NUM_ELEMENTS;
    localparam int W     = DATA_WIDTH;
    localparam int DEPTH = 2 * N;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][W-1:0] fifo_q, fifo_d;
    logic [CW-1:0]           cnt_q, cnt_d, pop, in_pop, shift, rem;
    logic [CW-1:0]           end_pos_q, end_pos_d;
    logic                    end_vld_q, end_vld_d, end_hit;
    logic [N-1:0][CW-1:0]    mask_pre, keep_pre;
    logic [N-1:0][W-1:0]     in_lane, comp, lane_val;
    logic                    load, in_xfer, err_d;

    assign in_lane    = in_data;
    // Space for a full beat exists whenever cnt <= N, so ready needs no input term.
    assign in_ready   = (cnt_q <= CW'(N));
    assign in_xfer    = in_valid && in_ready;
    assign load       = mask_valid && (cnt_q >= pop) && (!out_valid || out_ready);
    assign mask_ready = load;
    assign shift      = load ? pop : '0;
    assign rem        = cnt_q - shift;
    assign cnt_d      = rem + (in_xfer ? in_pop : '0);

    // Prefix counts: mask_pre[i] is the buffer index feeding lane i,
    // keep_pre[i] is the compacted slot of input lane i.
    always_comb begin
        pop    = '0;
        in_pop = '0;
        for (int i = 0; i < N; i++) begin
            mask_pre[i] = pop;
            keep_pre[i] = in_pop;
            if (mask_data[i]) pop    = pop + CW'(1);
            if (in_keep[i])   in_pop = in_pop + CW'(1);
        end
    end

    // Compact kept input lanes to the front, ascending lane order.
    always_comb begin
        comp = '0;
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++)
                if (in_keep[i] && keep_pre[i] == CW'(k)) comp[k] = in_lane[i];
    end

    // Drop the consumed head, then append this cycle's input after the survivors.
    always_comb begin
        fifo_d = fifo_q;
        for (int j = 0; j < DEPTH; j++) begin
            for (int s = 0; s <= N; s++)
                if (j + s < DEPTH && shift == CW'(s)) fifo_d[j] = fifo_q[(j + s) % DEPTH];
            if (in_xfer)
                for (int k = 0; k < N; k++)
                    if (CW'(k) < in_pop && CW'(j) == rem + CW'(k)) fifo_d[j] = comp[k];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        stream_expander_lane #(.DEPTH(DEPTH), .W(W), .CW(CW)) u_lane (
            .fifo (fifo_q),
            .sel  (mask_pre[i]),
            .en   (mask_data[i]),
            .elem (lane_val[i])
        );
    end

    // Packet-end marker tracks its element through shifts; err only observes.
    always_comb begin
        end_hit   = load && end_vld_q && (end_pos_q < pop);
        end_vld_d = end_vld_q && !end_hit;
        end_pos_d = (load && end_vld_q && !end_hit) ? end_pos_q - pop : end_pos_q;
        if (in_xfer && in_last && in_keep != '0) begin
            end_vld_d = 1'b1;
            end_pos_d = rem + in_pop - CW'(1);
        end
        err_d = err;
        if (in_xfer && in_last && in_keep == '0) err_d = 1'b1;
        if (load && mask_last && !(end_vld_q && pop != '0 && end_pos_q == pop - CW'(1)))
            err_d = 1'b1;
        if (load && !mask_last && end_hit) err_d = 1'b1;
    end

    // Buffer contents need no reset; cnt alone defines which entries are live.
    always_ff @(posedge clk) fifo_q <= fifo_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            end_vld_q <= 1'b0;
            end_pos_q <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_keep  <= '0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            end_vld_q <= end_vld_d;
            end_pos_q <= end_pos_d;
            err       <= err_d;
            if (load) begin
                out_data  <= lane_val;
                out_keep  <= mask_data;
                out_last  <= mask_last;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_expander.sv
// Randomized + directed bench for stream_expander (4 lanes x 8 bits) against
// a queue-based reference model of the element buffer and packet ends.
module tb_stream_expander;
    localparam int N = 4;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic [3:0]  in_keep = '0;
    logic        in_last = 1'b0, in_valid = 1'b0, in_ready;
    logic [3:0]  mask_data = '0;
    logic        mask_last = 1'b0, mask_valid = 1'b0, mask_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last, out_valid, err;
    logic        out_ready = 1'b1;

    always #5 clk = ~clk;

    stream_expander #(.NUM_ELEMENTS(N), .DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .mask_data(mask_data), .mask_last(mask_last),
        .mask_valid(mask_valid), .mask_ready(mask_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    int n_chk = 0;
    int n_pass = 0;

    // reference model: element queue with per-element packet-end flag
    byte unsigned q[$];
    bit           f[$];
    bit           m_ov, m_ol, m_err;
    logic [31:0]  m_od;
    logic [3:0]   m_ok;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        q.delete();
        f.delete();
        m_ov = 0; m_ol = 0; m_err = 0; m_od = '0; m_ok = '0;
    endtask

    task automatic idle();
        in_valid = 0; in_keep = '0; in_last = 0; in_data = '0;
        mask_valid = 0; mask_data = '0; mask_last = 0;
        out_ready = 1;
    endtask

    // One clock: check handshakes, advance model on the edge, check registers.
    task automatic cycle();
        int  pc, k, hi;
        bit  m_in_ready, m_load;
        #1;
        pc         = $countones(mask_data);
        m_in_ready = (q.size() <= N);
        m_load     = mask_valid && (q.size() >= pc) && (!m_ov || out_ready);
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
        chk("mask_ready", {31'd0, mask_ready}, {31'd0, m_load});
        @(posedge clk);
        if (rst) model_reset();
        else begin
            if (m_load) begin
                k = 0;
                m_od = '0;
                for (int i = 0; i < N; i++)
                    if (mask_data[i]) begin m_od[i*8 +: 8] = q[k]; k++; end
                if (mask_last) begin
                    if (pc == 0 || !f[pc-1]) m_err = 1;
                end else begin
                    for (int j = 0; j < pc; j++) if (f[j]) m_err = 1;
                end
                repeat (pc) begin void'(q.pop_front()); void'(f.pop_front()); end
                m_ok = mask_data; m_ol = mask_last; m_ov = 1;
            end else if (out_ready) m_ov = 0;
            if (in_valid && m_in_ready) begin
                if (in_last && in_keep == '0) m_err = 1;
                hi = -1;
                for (int i = 0; i < N; i++) if (in_keep[i]) hi = i;
                for (int i = 0; i < N; i++)
                    if (in_keep[i]) begin
                        q.push_back(in_data[i*8 +: 8]);
                        f.push_back(in_last && i == hi);
                    end
            end
        end
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        chk("out_data", out_data, m_od);
        chk("out_keep", {28'd0, out_keep}, {28'd0, m_ok});
        chk("out_last", {31'd0, out_last}, {31'd0, m_ol});
        chk("err", {31'd0, err}, {31'd0, m_err});
    endtask

    // Random traffic that keeps packet boundaries consistent.
    task automatic gen_random();
        int p = -1;
        for (int i = 0; i < f.size(); i++) if (f[i] && p < 0) p = i;
        in_valid = ($urandom % 4) != 0;
        in_keep  = 4'($urandom);
        in_data  = $urandom;
        in_last  = (p < 0) && (in_keep != '0) && ($urandom % 4 == 0);
        do mask_data = 4'($urandom); while (p >= 0 && $countones(mask_data) > p + 1);
        mask_last  = (p >= 0) && ($countones(mask_data) == p + 1);
        mask_valid = ($urandom % 4) != 0;
        out_ready  = ($urandom % 4) != 0;
    endtask

    task automatic basic_expand();
        idle();
        in_valid = 1; in_keep = 4'b0011; in_data = 32'h0000_2211;
        cycle();
        chk("basic_latency", {31'd0, out_valid}, 32'd0);
        idle();
        mask_valid = 1; mask_data = 4'b0101;
        cycle();
        chk("basic_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_data", out_data, 32'h0022_0011);
        chk("basic_keep", {28'd0, out_keep}, 32'h5);
        idle();
        cycle();
    endtask

    initial begin
        int exp_b, beats;
        logic [31:0] save;
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst = 0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        basic_expand();

        // spill: 8 elements fill past one beat, then drained one per mask
        in_valid = 1; in_keep = 4'hF; in_data = 32'h0403_0201;
        cycle();
        in_data = 32'h0807_0605;
        cycle();
        chk("spill_in_ready", {31'd0, in_ready}, 32'd0);
        idle();
        mask_valid = 1; mask_data = 4'b0001;
        exp_b = 1; beats = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (out_valid) begin
                chk("spill_seq", {24'd0, out_data[7:0]}, exp_b);
                exp_b++; beats++;
            end
        end
        chk("spill_beats", beats, 8);
        idle();
        cycle();

        // backpressure: output held for 5 cycles, then drained
        in_valid = 1; in_keep = 4'hF; in_data = 32'h4433_2211;
        cycle();
        idle();
        mask_valid = 1; mask_data = 4'b0011; out_ready = 0;
        cycle();
        save = out_data;
        chk("bp_first", save, 32'h0000_2211);
        repeat (5) begin
            cycle();
            chk("bp_hold", out_data, save);
            chk("bp_mask_ready", {31'd0, mask_ready}, 32'd0);
        end
        out_ready = 1;
        cycle();
        chk("bp_next", out_data, 32'h0000_4433);
        idle();
        repeat (2) cycle();

        // empty mask at full rate with an empty buffer
        mask_valid = 1; mask_data = 4'b0000;
        repeat (4) begin
            cycle();
            chk("empty_valid", {31'd0, out_valid}, 32'd1);
            chk("empty_keep", {28'd0, out_keep}, 32'd0);
        end
        idle();
        cycle();

        for (int c = 0; c < 400; c++) begin
            gen_random();
            cycle();
        end

        // reset mid-stream
        repeat (3) begin gen_random(); in_valid = 1; mask_valid = 0; cycle(); end
        idle();
        rst = 1;
        repeat (2) cycle();
        rst = 0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_err", {31'd0, err}, 32'd0);
        basic_expand();

        // packet end mismatch: 3-element packet closed after 2 elements
        in_valid = 1; in_keep = 4'b0111; in_data = 32'h0033_2211; in_last = 1;
        cycle();
        idle();
        mask_valid = 1; mask_data = 4'b0011; mask_last = 1;
        cycle();
        idle();
        cycle();
        chk("last_err", {31'd0, err}, 32'd1);
        repeat (3) cycle();
        chk("last_err_sticky", {31'd0, err}, 32'd1);
        rst = 1;
        cycle();
        rst = 0;
        chk("last_err_clr", {31'd0, err}, 32'd0);

        // in_last with an empty keep
        in_valid = 1; in_keep = 4'b0000; in_last = 1;
        cycle();
        idle();
        cycle();
        chk("empty_last_err", {31'd0, err}, 32'd1);
        rst = 1;
        cycle();
        rst = 0;
        idle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/stream_expander.md
STREAM_EXPANDER -- requirements
Module: stream_expander

Interface
REQ-001 SHALL have parameter NUM_ELEMENTS, default 8: lanes per beat, >=2.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: bits per element.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  in  NUM_ELEMENTS*DATA_WIDTH  packed input elements, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have port in_keep  in  NUM_ELEMENTS  input lane-valid mask.
REQ-007 SHALL have ports in_last  in  1, in_valid  in  1 and in_ready  out  1: input packet end and handshake.
REQ-008 SHALL have ports mask_data  in  NUM_ELEMENTS and mask_last  in  1: target lane pattern and packet end.
REQ-009 SHALL have ports mask_valid  in  1 and mask_ready  out  1: mask handshake.
REQ-010 SHALL have ports out_data  out  NUM_ELEMENTS*DATA_WIDTH and out_keep  out  NUM_ELEMENTS: expanded beat.
REQ-011 SHALL have ports out_last  out  1, out_valid  out  1 and out_ready  in  1.
REQ-012 SHALL have port err  out  1: sticky protocol-error flag.

Function
REQ-013 SHALL buffer up to 2*NUM_ELEMENTS elements in arrival order, tracked by an element count cnt.
REQ-014 SHALL append the elements of an input beat, taken from set in_keep bits in ascending lane order, at transfer (in_valid && in_ready).
REQ-015 SHALL drive in_ready = (cnt <= NUM_ELEMENTS) from registered state only.
REQ-016 SHALL, with pop = popcount(mask_data), set load = mask_valid && cnt >= pop && (!out_valid || out_ready).
REQ-017 SHALL drive mask_ready = load combinationally.
REQ-018 SHALL, on load, register out lane i = buffer element k, where k = number of set mask_data bits below lane i, for each lane i with mask_data[i]=1.
REQ-019 SHALL, on load, register out lane i = 0 for mask_data[i]=0, out_keep = mask_data, out_last = mask_last, out_valid = 1.
REQ-020 SHALL clear out_valid when out_ready && out_valid && !load.
REQ-021 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-022 SHALL, on load, remove the first pop elements, shift the rest to the head and append the same-cycle input after them.
REQ-023 SHALL update cnt to cnt - pop(if load) + popcount(in_keep)(if input transfer).
REQ-024 SHALL have a latency of 2 cycles: an element accepted in cycle t is presented with out_valid no earlier than cycle t+2.
REQ-025 SHALL sustain one output beat per cycle while inputs and masks are available and out_ready=1.
REQ-026 SHALL, for a mask with pop=0, emit a beat with out_keep=0 and all-zero data, regardless of cnt.
REQ-027 SHALL never deadlock: in_ready=0 implies cnt >= NUM_ELEMENTS+1 > pop.
REQ-028 SHALL record the buffer position of the element from an in_last beat as the packet end marker.
REQ-029 SHALL set err=1 for an in_last beat with in_keep=0.
REQ-030 SHALL set err=1 for a mask_last load whose last consumed element is not the marked end element.
REQ-031 SHALL set err=1 for a non-last load that consumes the marked end element.
REQ-032 SHALL keep err at 1 until reset; an error shall not alter datapath behaviour.

Reset
REQ-033 SHALL, while rst=1, force cnt=0, end marker invalid, out_valid=0, out_last=0, out_keep=0, out_data=0 and err=0.
REQ-034 SHALL drive in_ready=1 from the first cycle after reset.
REQ-035 SHALL discard buffered elements when reset is asserted mid-packet, with no residual output afterwards.

Verification (NUM_ELEMENTS=4, DATA_WIDTH=8)
REQ-036 SHALL cover reset: rst high 2 cycles mid-stream -> out_valid=0, in_ready=1, err=0, next packet expands correctly.
REQ-037 SHALL cover basic expansion: in_keep=0011 with lane0=0x11, lane1=0x22 at cycle t, mask 0101 -> cycle t+2 out lanes {0x11,0,0x22,0}, out_keep=0101.
REQ-038 SHALL cover spill: beats 0x01-0x04 and 0x05-0x08 (keep 1111), then 8 masks 0001 -> outputs 0x01..0x08 in order on lane0, and in_ready=0 while cnt>4.
REQ-039 SHALL cover backpressure: out_ready=0 for 5 cycles while valid -> out_* stable, mask_ready=0, and no element is lost or duplicated after release.
REQ-040 SHALL cover an empty mask: cnt=0, mask 0000 -> beat with out_keep=0000 emitted at full throughput.
REQ-041 SHALL cover last mismatch: 3-element input packet with in_last, mask 0011 with mask_last -> err=1 and it remains 1 until rst.
